rx_serial: RTL and testbench

//  Asynchronous serial receiver (UART RX): detects the start bit on dado_serial, samples each bit at mid-bit,

---
 rtl/rx_serial_pkg.sv | 30 +++
 rtl/rx_serial_uc.sv | 75 +++++++
 rtl/rx_serial.sv | 133 +++++++++++++
 tb/tb_rx_serial.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// Shared definitions for the UART receiver: state codes (also the db_estado debug codes) and defaults.
// Optional parity support is selected with the RX_PARITY_EN macro.
package rx_serial_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    VERIFICA    = 4'b0010,
    ESPERA      = 4'b0011,
    RECEPCAO    = 4'b0111,
    ESPERA_STOP = 4'b1011,
    ARMAZENA    = 4'b1110,
    FINAL_RX    = 4'b1111
  } estado_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_DATA_BITS    = 8;

`ifdef RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits shifted in after the start bit and before the stop bit.
  function automatic int frame_bits(input int data_bits);
    return data_bits + PARITY_BITS;
  endfunction

endpackage

// File: rtl/rx_serial_uc.sv
// Control unit of the UART receiver: Moore FSM only, datapath lives in rx_serial.
// Start is a high->low transition of the synchronized line seen while idle.
module rx_serial_uc
  import rx_serial_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_s,
  input  logic       rx_prev,
  input  logic       tick,
  input  logic       fim,
  output logic       zera,
  output logic       carrega_meio,
  output logic       desloca,
  output logic       conta,
  output logic       armazena,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;

  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d     = INICIAL;
    zera         = 1'b0;
    carrega_meio = 1'b0;
    desloca      = 1'b0;
    conta        = 1'b0;
    armazena     = 1'b0;
    pronto       = 1'b0;
    case (estado_q)
      INICIAL:     estado_d = (!rx_s && rx_prev) ? PREPARACAO : INICIAL;
      PREPARACAO: begin
        zera         = 1'b1;
        carrega_meio = 1'b1;
        estado_d     = VERIFICA;
      end
      VERIFICA: begin
        conta = 1'b1;
        if (tick) estado_d = rx_s ? INICIAL : ESPERA;
        else      estado_d = VERIFICA;
      end
      ESPERA: begin
        conta    = 1'b1;
        estado_d = tick ? RECEPCAO : ESPERA;
      end
      RECEPCAO: begin
        conta    = 1'b1;
        desloca  = 1'b1;
        estado_d = fim ? ESPERA_STOP : ESPERA;
      end
      ESPERA_STOP: begin
        conta    = 1'b1;
        estado_d = tick ? ARMAZENA : ESPERA_STOP;
      end
      ARMAZENA: begin
        armazena = 1'b1;
        estado_d = FINAL_RX;
      end
      FINAL_RX: begin
        pronto   = 1'b1;
        estado_d = INICIAL;
      end
      default:     estado_d = INICIAL;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: rtl/rx_serial.sv
// UART receiver datapath: synchronizer, bit-period tick counter, bit counter, shift register and result flags.
// Define RX_PARITY_EN to receive an even-parity bit after the data bits.
module rx_serial
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe,
  output logic [DATA_BITS-1:0] dados,
  output logic                 tem_dado,
  output logic                 pronto,
  output logic                 erro_stop,
  output logic                 erro_paridade,
  output logic                 erro_overrun,
  output logic [3:0]           db_estado
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int TC_W       = $clog2(CLKS_PER_BIT);
  localparam int BC_W       = $clog2(FRAME_BITS + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(CLKS_PER_BIT - 1);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);

  logic                  rx_meta_q, rx_s_q, rx_prev_q;
  logic [TC_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  dados_q, dados_d;
  logic                  tem_dado_q, tem_dado_d;
  logic                  erro_stop_q, erro_stop_d;
  logic                  erro_par_q, erro_par_d;
  logic                  erro_ov_q, erro_ov_d;

  logic tick, fim;
  logic zera, carrega_meio, desloca, conta, armazena;

  rx_serial_uc u_uc (
    .clock        (clock),
    .reset        (reset),
    .rx_s         (rx_s_q),
    .rx_prev      (rx_prev_q),
    .tick         (tick),
    .fim          (fim),
    .zera         (zera),
    .carrega_meio (carrega_meio),
    .desloca      (desloca),
    .conta        (conta),
    .armazena     (armazena),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  assign tick = (tick_cnt_q == TC_LAST);
  assign fim  = (bit_cnt_q == BC_LAST);

  // The tick counter free-runs through every waiting/sampling state so bit periods stay exact.
  always_comb begin
    tick_cnt_d = '0;
    if (carrega_meio)  tick_cnt_d = TC_HALF;
    else if (conta)    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (zera) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (desloca) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      shift_d   = {rx_s_q, shift_q[FRAME_BITS-1:1]};
    end
  end

  always_comb begin
    dados_d     = dados_q;
    tem_dado_d  = tem_dado_q;
    erro_stop_d = erro_stop_q;
    erro_ov_d   = erro_ov_q;
    if (armazena) begin
      dados_d     = shift_q[DATA_BITS-1:0];
      erro_stop_d = ~rx_s_q;
      tem_dado_d  = 1'b1;
      if (tem_dado_q && !recebe) erro_ov_d = 1'b1;
    end else if (recebe) begin
      tem_dado_d = 1'b0;
      erro_ov_d  = 1'b0;
    end
`ifdef RX_PARITY_EN
    erro_par_d = armazena ? ^shift_q : erro_par_q;
`else
    erro_par_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dados_q     <= '0;
      tem_dado_q  <= 1'b0;
      erro_stop_q <= 1'b0;
      erro_par_q  <= 1'b0;
      erro_ov_q   <= 1'b0;
    end else begin
      rx_meta_q   <= dado_serial;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dados_q     <= dados_d;
      tem_dado_q  <= tem_dado_d;
      erro_stop_q <= erro_stop_d;
      erro_par_q  <= erro_par_d;
      erro_ov_q   <= erro_ov_d;
    end
  end

  assign dados         = dados_q;
  assign tem_dado      = tem_dado_q;
  assign erro_stop     = erro_stop_q;
  assign erro_paridade = erro_par_q;
  assign erro_overrun  = erro_ov_q;

endmodule

// File: tb/tb_rx_serial.sv
// Bench for rx_serial: frames are driven bit by bit, expected results queued per frame and
// checked by a monitor whenever pronto pulses. Honours RX_PARITY_EN.
module tb_rx_serial;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          dado_serial = 1'b1;
  logic          recebe = 1'b0;
  logic [DW-1:0] dados;
  logic          tem_dado, pronto, erro_stop, erro_paridade, erro_overrun;
  logic [3:0]    db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected entry: {erro_overrun, erro_paridade, erro_stop, dados}
  logic [DW+2:0] exp_q[$];

  // Frame-level model of the consumer-visible state.
  logic          model_pending = 1'b0;
  logic          model_ov      = 1'b0;
  logic [DW-1:0] model_dados   = '0;

  rx_serial #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .dado_serial   (dado_serial),
    .recebe        (recebe),
    .dados         (dados),
    .tem_dado      (tem_dado),
    .pronto        (pronto),
    .erro_stop     (erro_stop),
    .erro_paridade (erro_paridade),
    .erro_overrun  (erro_overrun),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pronto pulse must match the oldest queued frame.
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pronto", 32'd1, 32'd0);
      end else begin
        logic [DW+2:0] e;
        e = exp_q.pop_front();
        check("dados", 32'(dados), 32'(e[DW-1:0]));
        check("erro_stop", 32'(erro_stop), 32'(e[DW]));
        check("erro_paridade", 32'(erro_paridade), 32'(e[DW+1]));
        check("erro_overrun", 32'(erro_overrun), 32'(e[DW+2]));
        check("tem_dado_at_pronto", 32'(tem_dado), 32'd1);
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clock);
    dado_serial = b;
    repeat (CPB - 1) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clock);
    dado_serial = 1'b1;
    repeat (n * CPB - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit, input logic par_flip);
    logic ov_e, par_e;
`ifdef RX_PARITY_EN
    par_e = par_flip;
`else
    par_e = 1'b0;
`endif
    ov_e = model_ov | model_pending;
    exp_q.push_back({ov_e, par_e, ~stop_bit, data});
    model_ov      = ov_e;
    model_pending = 1'b1;
    model_dados   = data;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(data[i]);
`ifdef RX_PARITY_EN
    drive_bit((^data) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic pulse_recebe();
    @(negedge clock);
    recebe = 1'b1;
    @(negedge clock);
    recebe = 1'b0;
    model_pending = 1'b0;
    model_ov      = 1'b0;
    check("recebe_tem_dado", 32'(tem_dado), 32'd0);
    check("recebe_overrun", 32'(erro_overrun), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int gap;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_dados", 32'(dados), 32'd0);
    check("rst_tem_dado", 32'(tem_dado), 32'd0);
    check("rst_erros", 32'({erro_stop, erro_paridade, erro_overrun}), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    idle_bits(2);

    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(1);

    // Short low glitch must be rejected as a false start.
    @(negedge clock);
    dado_serial = 1'b0;
    repeat (4) @(negedge clock);
    dado_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("glitch_estado", 32'(db_estado), 32'd0);
    check("glitch_dados", 32'(dados), 32'(model_dados));
    check("glitch_tem_dado", 32'(tem_dado), 32'(model_pending));

    pulse_recebe();
    send_frame(8'hA3, 1'b0, 1'b0);
    idle_bits(1);
    send_frame(8'h0F, 1'b1, 1'b0);
    pulse_recebe();

    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    check("b2b_overrun_held", 32'(erro_overrun), 32'd1);
    pulse_recebe();
    idle_bits(1);

    send_frame(8'h99, 1'b1, 1'b0);
    // Reset in the middle of data bit 4.
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    @(negedge clock);
    dado_serial = d[4];
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    dado_serial = 1'b1;
    model_pending = 1'b0;
    model_ov      = 1'b0;
    model_dados   = '0;
    check("midrst_dados", 32'(dados), 32'd0);
    check("midrst_flags", 32'({tem_dado, pronto, erro_stop, erro_paridade, erro_overrun}), 32'd0);
    check("midrst_estado", 32'(db_estado), 32'd0);
    idle_bits(2);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(1);

    // Break: line held low well past the stop bit produces exactly one frame.
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clock);
    check("break_estado", 32'(db_estado), 32'd0);
    idle_bits(2);
    check("break_idle_estado", 32'(db_estado), 32'd0);

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
`endif

    for (int n = 0; n < 24; n++) begin
      logic stop_bit, flip;
      d        = DW'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      flip     = ($urandom_range(0, 3) == 0);
      send_frame(d, stop_bit, flip);
      gap = $urandom_range(0, 2);
      if (!stop_bit && gap == 0) gap = 1;
      if ($urandom_range(0, 1) == 1) pulse_recebe();
      if (gap > 0) idle_bits(gap);
    end

    idle_bits(3);
    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    check("final_tem_dado", 32'(tem_dado), 32'(model_pending));
    check("final_dados", 32'(dados), 32'(model_dados));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
